// File: rtl/fp_mont_alu.sv
// fp_mont_alu: SM9 Fp arithmetic core -- bit-serial Montgomery multiply (A*B*2^-W mod P)
// plus combinational modular add/subtract. Rev 1.0
`default_nettype none

module fp_mont_alu #(
  parameter int            W = 256,
  parameter logic [W-1:0]  P = 256'hB640000002A3A6F1D603AB4FF58EC74521F2934B1A7AEEDBE56F9B27E351457D
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic [2:0]   select,
  input  logic [W-1:0] data_ina,
  input  logic [W-1:0] data_inb,
  output logic [W-1:0] data_mm,
  output logic         end_mm,
  output logic [W-1:0] data_as
);

  localparam int           CW       = $clog2(W);
  localparam logic [2:0]   OP_MUL   = 3'b100;
  localparam logic [2:0]   OP_SUB   = 3'b010;
  localparam logic [2:0]   OP_ADD   = 3'b001;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  // (T + P) >> 1 for odd T equals (T >> 1) + (P >> 1) + 1, since P is odd
  localparam logic [W:0]   P_HALF1  = {2'b00, P[W-1:1]} + {{W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MUL   = 3'd1,
    S_FIN   = 3'd2,
    S_DONE  = 3'd3,
    S_REARM = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W+1:0]   t_q, t_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   data_mm_q, data_mm_d;

  logic [W+1:0]   t_add;
  logic [W:0]     t_half;
  logic           t_ge_p;
  logic [W-1:0]   t_fin;

  always_comb begin
    t_add  = t_q + (a_q[cnt_q] ? {2'b00, b_q} : {(W+2){1'b0}});
    t_half = t_add[W+1:1] + (t_add[0] ? P_HALF1 : {(W+1){1'b0}});
    t_ge_p = (t_q >= {2'b00, P});
    // T < 2P, so the low W bits of T-P are exact whenever T >= P
    t_fin  = t_ge_p ? (t_q[W-1:0] - P) : t_q[W-1:0];
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    t_d       = t_q;
    cnt_d     = cnt_q;
    data_mm_d = data_mm_q;
    unique case (state_q)
      S_IDLE: begin
        if (select == OP_MUL) begin
          a_d     = data_ina;
          b_d     = data_inb;
          t_d     = '0;
          cnt_d   = '0;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        if (select != OP_MUL) begin
          state_d = S_IDLE;
        end else begin
          t_d   = {1'b0, t_half};
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) state_d = S_FIN;
        end
      end
      S_FIN: begin
        if (select != OP_MUL) begin
          state_d = S_IDLE;
        end else begin
          data_mm_d = t_fin;
          state_d   = S_DONE;
        end
      end
      S_DONE:  state_d = S_REARM;
      S_REARM: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      t_q       <= '0;
      cnt_q     <= '0;
      data_mm_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      t_q       <= t_d;
      cnt_q     <= cnt_d;
      data_mm_q <= data_mm_d;
    end
  end

  assign data_mm = data_mm_q;
  assign end_mm  = (state_q == S_DONE);

  logic [W-1:0] as_diff;
  logic [W:0]   as_sum;
  logic [W-1:0] as_sub;
  logic [W-1:0] as_add;

  always_comb begin
    as_diff = data_ina - data_inb;
    as_sub  = (data_ina >= data_inb) ? as_diff : (as_diff + P);
    as_sum  = {1'b0, data_ina} + {1'b0, data_inb};
    as_add  = (as_sum >= {1'b0, P}) ? (as_sum[W-1:0] - P) : as_sum[W-1:0];
    data_as = '0;
    if (select == OP_SUB)      data_as = as_sub;
    else if (select == OP_ADD) data_as = as_add;
  end

endmodule

`default_nettype wire
